// File: rtl/intc_prio_arbiter.sv
// Clocked interrupt priority arbiter: latches requests from NUM_BUS x NUM_CHAN
// sources, masks them per channel and presents one winner on a valid/ack handshake.
module intc_prio_arbiter #(
    parameter int NUM_CHAN  = 9,
    parameter int NUM_BUS   = 3,
    parameter int EDGE_MODE = 1,
    parameter int CHAN_W    = 4,
    parameter int BUS_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_BUS*NUM_CHAN-1:0] req_i,
    input  logic [NUM_CHAN-1:0]         chan_en_i,
    input  logic                        irq_ack_i,
    output logic                        irq_valid_o,
    output logic [BUS_W-1:0]            irq_bus_o,
    output logic [CHAN_W-1:0]           irq_chan_o,
    output logic [NUM_BUS-1:0]          bus_active_o
);

    localparam int NUM_SRC = NUM_BUS * NUM_CHAN;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [NUM_SRC-1:0]    req_q_r;
    logic [NUM_SRC-1:0]    pend_r;
    logic [NUM_SRC-1:0]    pend_nxt_s;
    logic [NUM_SRC-1:0]    elig_s;
    logic [NUM_SRC-1:0]    clr_s;
    logic [NUM_BUS-1:0]    bus_active_s;
    logic [NUM_BUS-1:0]    bus_active_r;
    logic                  win_found_s;
    logic [BUS_W-1:0]      win_bus_s;
    logic [CHAN_W-1:0]     win_chan_s;
    logic                  irq_valid_r;
    logic                  valid_nxt_s;
    logic [BUS_W-1:0]      irq_bus_r;
    logic [BUS_W-1:0]      bus_nxt_s;
    logic [CHAN_W-1:0]     irq_chan_r;
    logic [CHAN_W-1:0]     chan_nxt_s;
    logic                  ack_clear_s;

    // Eligibility: pending bits gated by the shared channel enable, plus per-bus OR.
    always_comb begin
        elig_s       = '0;
        bus_active_s = '0;
        for (int b = 0; b < NUM_BUS; b++) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                elig_s[b*NUM_CHAN+c] = pend_r[b*NUM_CHAN+c] & chan_en_i[c];
                bus_active_s[b]      = bus_active_s[b] | elig_s[b*NUM_CHAN+c];
            end
        end
    end

    // Fixed priority: the first eligible source in bus-then-channel order wins.
    always_comb begin
        win_found_s = 1'b0;
        win_bus_s   = '0;
        win_chan_s  = '0;
        for (int b = 0; b < NUM_BUS; b++) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (elig_s[b*NUM_CHAN+c] && !win_found_s) begin
                    win_found_s = 1'b1;
                    win_bus_s   = BUS_W'(b);
                    win_chan_s  = CHAN_W'(c);
                end else begin
                    win_found_s = win_found_s;
                end
            end
        end
    end

    // Handshake FSM: latch a winner in IDLE, hold it in GRANT until acknowledged.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = irq_valid_r;
        bus_nxt_s   = irq_bus_r;
        chan_nxt_s  = irq_chan_r;
        ack_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_nxt_s = ST_GRANT;
                    valid_nxt_s = 1'b1;
                    bus_nxt_s   = win_bus_s;
                    chan_nxt_s  = win_chan_s;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (irq_ack_i) begin
                    state_nxt_s = ST_IDLE;
                    valid_nxt_s = 1'b0;
                    ack_clear_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Acknowledge clears only the source currently presented.
    always_comb begin
        clr_s = '0;
        for (int b = 0; b < NUM_BUS; b++) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                clr_s[b*NUM_CHAN+c] = ack_clear_s && (irq_bus_r == BUS_W'(b)) &&
                                      (irq_chan_r == CHAN_W'(c));
            end
        end
    end

    // Pending update: a new edge beats a simultaneous ack clear; level mode just samples.
    always_comb begin
        if (EDGE_MODE != 0) begin
            pend_nxt_s = (pend_r & ~clr_s) | (req_i & ~req_q_r);
        end else begin
            pend_nxt_s = req_i;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            req_q_r      <= '0;
            pend_r       <= '0;
            bus_active_r <= '0;
            irq_valid_r  <= 1'b0;
            irq_bus_r    <= '0;
            irq_chan_r   <= '0;
        end else begin
            state_r      <= state_nxt_s;
            req_q_r      <= req_i;
            pend_r       <= pend_nxt_s;
            bus_active_r <= bus_active_s;
            irq_valid_r  <= valid_nxt_s;
            irq_bus_r    <= bus_nxt_s;
            irq_chan_r   <= chan_nxt_s;
        end
    end

    assign irq_valid_o  = irq_valid_r;
    assign irq_bus_o    = irq_bus_r;
    assign irq_chan_o   = irq_chan_r;
    assign bus_active_o = bus_active_r;

endmodule

// File: tb/tb_intc_prio_arbiter.sv
// Bench for intc_prio_arbiter: an edge-mode and a level-mode instance driven side by
// side, compared every cycle against a flat-index reference model, plus directed checks.
module tb_intc_prio_arbiter;

    localparam int NC = 9;
    localparam int NB = 3;
    localparam int NS = NC * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] req = '0;
    logic [NC-1:0] en = '1;
    logic [1:0]    ack = 2'b00;

    logic          v_o   [2];
    logic [1:0]    bus_o [2];
    logic [3:0]    chan_o[2];
    logic [2:0]    act_o [2];

    logic [NS-1:0] m_pend [2];
    logic [NS-1:0] m_reqq [2];
    logic          m_valid[2];
    int            m_bus  [2];
    int            m_chan [2];
    logic [2:0]    m_act  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    intc_prio_arbiter #(.NUM_CHAN(NC), .NUM_BUS(NB), .EDGE_MODE(1), .CHAN_W(4), .BUS_W(2)) u_edge (
        .clk(clk), .rst_n(rst_n), .req_i(req), .chan_en_i(en), .irq_ack_i(ack[0]),
        .irq_valid_o(v_o[0]), .irq_bus_o(bus_o[0]), .irq_chan_o(chan_o[0]), .bus_active_o(act_o[0]));

    intc_prio_arbiter #(.NUM_CHAN(NC), .NUM_BUS(NB), .EDGE_MODE(0), .CHAN_W(4), .BUS_W(2)) u_level (
        .clk(clk), .rst_n(rst_n), .req_i(req), .chan_en_i(en), .irq_ack_i(ack[1]),
        .irq_valid_o(v_o[1]), .irq_bus_o(bus_o[1]), .irq_chan_o(chan_o[1]), .bus_active_o(act_o[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = '0; m_reqq[i] = '0; m_valid[i] = 1'b0;
            m_bus[i] = 0; m_chan[i] = 0; m_act[i] = '0;
        end
    endtask

    // One clock edge of the reference: winner = lowest flat index among eligible sources.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [NS-1:0] el;
            logic [NS-1:0] clr;
            logic [2:0]    act;
            int            win;
            el = '0; clr = '0; act = '0; win = -1;
            for (int s = 0; s < NS; s++) el[s] = m_pend[i][s] & en[s % NC];
            for (int s = 0; s < NS; s++) if (el[s]) act[s / NC] = 1'b1;
            for (int s = NS - 1; s >= 0; s--) if (el[s]) win = s;
            if (!m_valid[i]) begin
                if (win >= 0) begin
                    m_valid[i] = 1'b1; m_bus[i] = win / NC; m_chan[i] = win % NC;
                end
            end else if (ack[i]) begin
                m_valid[i] = 1'b0;
                clr[m_bus[i] * NC + m_chan[i]] = 1'b1;
            end
            if (i == 0) m_pend[i] = (m_pend[i] & ~clr) | (req & ~m_reqq[i]);
            else        m_pend[i] = req;
            m_reqq[i] = req;
            m_act[i]  = act;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "edge_valid" : "level_valid", 32'(v_o[i]), 32'(m_valid[i]));
            chk(i == 0 ? "edge_bus" : "level_bus", 32'(bus_o[i]), 32'(m_bus[i]));
            chk(i == 0 ? "edge_chan" : "level_chan", 32'(chan_o[i]), 32'(m_chan[i]));
            chk(i == 0 ? "edge_active" : "level_active", 32'(act_o[i]), 32'(m_act[i]));
        end
    endtask

    task automatic cycle(input logic [NS-1:0] r, input logic [NC-1:0] e, input logic [1:0] a);
        req = r; en = e; ack = a;
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        check_all();
    endtask

    // Directed expectation on one instance: {valid, bus, chan}.
    task automatic expect_irq(input string tag, input int i, input logic v, input int b, input int c);
        chk(tag, {25'd0, v_o[i], bus_o[i], chan_o[i]}, {25'd0, v, 2'(b), 4'(c)});
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_now_valid", 32'(v_o[0]), 32'd0);
        chk("rst_now_bus_chan", {26'd0, bus_o[0], chan_o[0]}, 32'd0);
        chk("rst_now_active", 32'(act_o[0]), 32'd0);
        cycle('0, en, 2'b00);
        rst_n = 1'b1;
    endtask

    localparam logic [NS-1:0] ONE = 27'd1;
    localparam logic [NC-1:0] ALL = 9'h1FF;

    initial begin
        model_reset();
        cycle('0, ALL, 2'b00);
        chk("reset_state", {22'd0, v_o[0], bus_o[0], chan_o[0], act_o[0]}, 32'd0);
        rst_n = 1'b1;
        cycle('0, ALL, 2'b00);

        // Single pulse on bus1/ch4 (bit 13)
        cycle(ONE << 13, ALL, 2'b00);
        expect_irq("pulse_latency1", 0, 1'b0, 0, 0);
        cycle('0, ALL, 2'b00);
        expect_irq("pulse_grant", 0, 1'b1, 1, 4);
        chk("pulse_active", 32'(act_o[0]), 32'd2);
        for (int k = 0; k < 3; k++) cycle('0, ALL, 2'b00);
        expect_irq("pulse_hold", 0, 1'b1, 1, 4);
        cycle('0, ALL, 2'b11);
        expect_irq("pulse_acked", 0, 1'b0, 1, 4);
        for (int k = 0; k < 5; k++) cycle('0, ALL, 2'b00);
        expect_irq("pulse_no_regrant", 0, 1'b0, 1, 4);

        // Priority: bus2/ch0 and bus0/ch8 together
        cycle((ONE << 18) | (ONE << 8), ALL, 2'b00);
        cycle('0, ALL, 2'b00);
        expect_irq("prio_first", 0, 1'b1, 0, 8);
        cycle((ONE << 1), ALL, 2'b00);
        expect_irq("prio_no_preempt", 0, 1'b1, 0, 8);
        cycle('0, ALL, 2'b11);
        expect_irq("prio_gap", 0, 1'b0, 0, 8);
        cycle('0, ALL, 2'b00);
        expect_irq("prio_second", 0, 1'b1, 0, 1);
        cycle('0, ALL, 2'b11);
        cycle('0, ALL, 2'b00);
        expect_irq("prio_third", 0, 1'b1, 2, 0);
        cycle('0, ALL, 2'b11);
        for (int k = 0; k < 3; k++) cycle('0, ALL, 2'b00);
        expect_irq("prio_idle", 0, 1'b0, 2, 0);

        // Masking of channel 3, then unmask
        cycle(ONE << 3, ALL & ~9'h008, 2'b00);
        for (int k = 0; k < 10; k++) begin
            cycle('0, ALL & ~9'h008, 2'b00);
            expect_irq("mask_no_irq", 0, 1'b0, 2, 0);
            chk("mask_active", 32'(act_o[0]), 32'd0);
        end
        cycle('0, ALL, 2'b00);
        expect_irq("unmask_grant", 0, 1'b1, 0, 3);
        chk("unmask_active", 32'(act_o[0]), 32'd1);
        cycle('0, ALL & ~9'h008, 2'b00);
        expect_irq("unmask_no_retract", 0, 1'b1, 0, 3);
        cycle('0, ALL, 2'b11);
        cycle('0, ALL, 2'b00);

        // Set-vs-clear collision on bus0/ch5
        cycle(ONE << 5, ALL, 2'b00);
        cycle('0, ALL, 2'b00);
        expect_irq("coll_grant", 0, 1'b1, 0, 5);
        cycle(ONE << 5, ALL, 2'b11);
        expect_irq("coll_gap", 0, 1'b0, 0, 5);
        cycle('0, ALL, 2'b00);
        expect_irq("coll_regrant", 0, 1'b1, 0, 5);
        cycle('0, ALL, 2'b11);
        cycle('0, ALL, 2'b00);

        // Level mode: held bus0/ch0 re-granted after every ack
        cycle(ONE, ALL, 2'b00);
        cycle(ONE, ALL, 2'b00);
        expect_irq("lvl_grant", 1, 1'b1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            cycle(ONE, ALL, 2'b11);
            expect_irq("lvl_gap", 1, 1'b0, 0, 0);
            cycle(ONE, ALL, 2'b00);
            expect_irq("lvl_regrant", 1, 1'b1, 0, 0);
        end
        cycle('0, ALL, 2'b00);
        cycle('0, ALL, 2'b11);
        for (int k = 0; k < 4; k++) begin
            cycle('0, ALL, 2'b00);
            expect_irq("lvl_dropped", 1, 1'b0, 0, 0);
        end
        cycle('0, ALL, 2'b01);

        // Reset in the middle of a grant
        cycle(ONE << 13, ALL, 2'b00);
        cycle('0, ALL, 2'b00);
        expect_irq("pre_reset_grant", 0, 1'b1, 1, 4);
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            cycle('0, ALL, 2'b00);
            expect_irq("post_reset_quiet", 0, 1'b0, 0, 0);
        end
        cycle(ONE << 2, ALL, 2'b00);
        cycle('0, ALL, 2'b00);
        expect_irq("post_reset_grant", 0, 1'b1, 0, 2);
        cycle('0, ALL, 2'b11);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic [NS-1:0] r;
            logic [NC-1:0] e;
            r = NS'($urandom & $urandom & $urandom);
            e = NC'($urandom | $urandom);
            cycle(r, e, 2'($urandom));
            if ($urandom_range(0, 299) == 0) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intc_prio_arbiter.md
Name: intc_prio_arbiter

Overview:
- Parametrised, clocked successor to the 27-channel (9 channels x 3 buses) combinational interrupt priority encoder.
- Latches requests from NUM_BUS buses of NUM_CHAN channels and applies a shared per-channel enable.
- Arbitrates by fixed bus-then-channel priority and presents one winner at a time on a valid/ack handshake.
- Sits between peripheral request lines and the CPU interrupt interface.

Parameters:
NUM_CHAN, 9, channels per bus (1..15)
NUM_BUS, 3, number of request buses (1..4)
EDGE_MODE, 1, 1 = rising-edge latched requests, 0 = level requests
CHAN_W, 4, width of irq_chan_o; must satisfy 2**CHAN_W >= NUM_CHAN
BUS_W, 2, width of irq_bus_o; must satisfy 2**BUS_W >= NUM_BUS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_i  input  NUM_BUS*NUM_CHAN  requests, bus-major: bit b*NUM_CHAN+c = bus b, channel c
chan_en_i  input  NUM_CHAN  per-channel enable, applied to all buses
irq_ack_i  input  1  acknowledge of the presented interrupt
irq_valid_o  output  1  interrupt presented
irq_bus_o  output  BUS_W  bus index of the presented interrupt
irq_chan_o  output  CHAN_W  channel index of the presented interrupt
bus_active_o  output  NUM_BUS  per bus: registered OR of enabled pending bits

Behaviour:
- Reset: single clock, asynchronous active-low reset rst_n.
  - While rst_n=0: all state and outputs are 0 (pending, req history, FSM=IDLE, irq_valid_o, irq_bus_o, irq_chan_o, bus_active_o).
  - Reset takes effect immediately, including in the middle of a grant.
- Pending register pend[NUM_BUS*NUM_CHAN]:
  - EDGE_MODE=1: req_q <= req_i each cycle. pend bit sets on req_i & ~req_q. It clears only on ack of that source. If a set and a clear hit the same bit in the same cycle, set wins.
  - EDGE_MODE=0: pend <= req_i each cycle. Ack has no clearing effect.
- Eligibility: elig[b][c] = pend[b][c] & chan_en_i[c]. Masked edge-mode pending bits are retained, not dropped.
- Priority: lowest bus index wins; within a bus, lowest channel index wins. Pure combinational function of elig.
- FSM states:
  - IDLE: irq_valid_o=0. If any elig bit is set, latch the winner into irq_bus_o/irq_chan_o, set irq_valid_o=1, go to GRANT.
  - GRANT: irq_valid_o=1; irq_bus_o/irq_chan_o are held stable. A later higher-priority request does not pre-empt. Dropping chan_en_i for the granted channel does not retract. On irq_ack_i=1: clear the granted pend bit (edge mode), irq_valid_o <= 0, go to IDLE.
  - IDLE always lasts at least one cycle after an ack (one-cycle gap between grants).
- irq_ack_i is ignored when irq_valid_o=0.
- Latency:
  - From a request sampled at edge k: pend=1 after edge k; irq_valid_o=1 after edge k+1 (2 cycles).
  - From enable assertion on an already-pending bit: 1 cycle.
- bus_active_o[b] <= |elig[b][*] each cycle (1 cycle behind elig). It reflects eligibility, not the grant.
- irq_bus_o/irq_chan_o keep their last value while irq_valid_o=0. They are zero only after reset.
- The result is fully determined for all parameter values. Unused encodings of irq_bus_o/irq_chan_o are never produced.

Test Plan:
- Reset: assert rst_n=0 mid-GRANT (irq_valid_o=1) -> all outputs 0 immediately. After release, no grant until a new rising edge appears on req_i (EDGE_MODE=1).
- Edge, defaults: chan_en_i=all 1, 1-cycle pulse on bus1/ch4 (bit 13) at edge k -> bus_active_o=3'b010 after k+1. irq_valid_o=1, bus=1, chan=4 after k+1, held until ack. After ack: irq_valid_o=0 and never re-granted.
- Priority: pulse bus2/ch0 and bus0/ch8 in the same cycle -> first grant bus=0, chan=8. Ack -> one IDLE cycle -> grant bus=2, chan=0. Ack -> idle.
- Masking: chan_en_i[3]=0, pulse bus0/ch3 -> no irq and bus_active_o=0 for 10 cycles. Set chan_en_i[3]=1 -> irq_valid_o=1, bus=0, chan=3 one cycle later.
- Set-vs-clear collision: a new rising edge on the granted source in the same cycle as the ack -> irq_valid_o=0 for one cycle, then the same bus/chan is re-presented.
- Level mode (EDGE_MODE=0): hold bus0/ch0 high -> re-granted after every ack with a 1-cycle gap. Drop the request -> no further grant after the current ack.
